// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small byte FIFO; back-to-back frames leave no idle gap.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Busy,
  output logic       o_Tx_Done,
  output logic       o_Fifo_Empty
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   baud_reg;
  logic [2:0]      bit_reg;
  logic [7:0]      shift_reg;
  logic            serial_reg;
  logic            done_reg;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;

  logic            push;
  logic            pop;
  logic            baud_last;

  assign o_Tx_Ready   = (count_reg != FIFO_FULL);
  assign o_Fifo_Empty = (count_reg == '0);
  assign o_Tx_Serial  = serial_reg;
  assign o_Tx_Done    = done_reg;
  assign o_Tx_Busy    = (state_reg != ST_IDLE);

  assign baud_last = (baud_reg == BAUD_LAST);
  assign push      = i_Tx_DV && o_Tx_Ready;
  // The FSM takes the next byte either from IDLE or on the last stop-bit cycle.
  assign pop       = !o_Fifo_Empty &&
                     ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_last));

  always_ff @(posedge i_Clock) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW + 1)'(1);
        2'b01:   count_reg <= count_reg - (PW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Line level is registered from the current state, so it lags the state by one cycle.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg  <= ST_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      serial_reg <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          serial_reg <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr_reg];
            baud_reg  <= '0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          serial_reg <= 1'b0;
          if (baud_last) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            state_reg <= ST_DATA;
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        ST_DATA: begin
          serial_reg <= shift_reg[bit_reg];
          if (baud_last) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
              bit_reg <= '0;
`ifdef UART_TX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end else begin
              bit_reg <= bit_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          serial_reg <= ^shift_reg;
          if (baud_last) begin
            baud_reg  <= '0;
            state_reg <= ST_STOP;
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          serial_reg <= 1'b1;
          if (baud_last) begin
            baud_reg <= '0;
            done_reg <= 1'b1;
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr_reg];
              state_reg <= ST_START;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          serial_reg <= 1'b1;
          baud_reg   <= '0;
          bit_reg    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter at CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Honours UART_TX_PARITY_EN to select 8N1 or 8E1 frame expectations.
module tb_uart_transmitter;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready, tx_serial, tx_busy, tx_done, fifo_empty;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_bytes [0:31];

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Tx_DV      (tx_dv),
    .i_Tx_Byte    (tx_byte),
    .o_Tx_Ready   (tx_ready),
    .o_Tx_Serial  (tx_serial),
    .o_Tx_Busy    (tx_busy),
    .o_Tx_Done    (tx_done),
    .o_Fifo_Empty (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level t cycles after the edge that accepted the first byte.
  function automatic logic line_bit(input int n, input int t);
    int r, f, b;
    if (t < 2 || t >= 2 + n * FL) return 1'b1;
    r = (t - 2) % FL;
    f = (t - 2) / FL;
    b = r / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return exp_bytes[5'(f)][3'(b - 1)];
    if (FB == 11 && b == 9) return ^exp_bytes[5'(f)];
    return 1'b1;
  endfunction

  task automatic run_stream(input int n_wr, input int n_tx, input string name);
    fork
      begin
        for (int k = 0; k < n_wr; k++) begin
          tx_dv = 1'b1;
          tx_byte = exp_bytes[5'(k)];
          @(negedge clk);
          check($sformatf("%s ready k=%0d", name, k), 32'(tx_ready), 32'(k < DEPTH));
        end
        tx_dv = 1'b0;
      end
      begin
        for (int t = 0; t < 2 + n_tx * FL + 6; t++) begin
          @(negedge clk);
          check($sformatf("%s serial t=%0d", name, t), 32'(tx_serial), 32'(line_bit(n_tx, t)));
          check($sformatf("%s done t=%0d", name, t), 32'(tx_done),
                32'(t >= 2 && t < 2 + n_tx * FL && ((t - 2) % FL) == FL - 1));
          check($sformatf("%s busy t=%0d", name, t), 32'(tx_busy),
                32'(t >= 1 && t <= n_tx * FL));
        end
      end
    join
    check({name, " empty at end"}, 32'(fifo_empty), 32'd1);
    $display("[TB] %s: %0d bytes written, %0d frames checked", name, n_wr, n_tx);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset serial", 32'(tx_serial), 32'd1);
    check("reset busy", 32'(tx_busy), 32'd0);
    check("reset done", 32'(tx_done), 32'd0);
    check("reset empty", 32'(fifo_empty), 32'd1);
    check("reset ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle serial", 32'(tx_serial), 32'd1);
    check("idle busy", 32'(tx_busy), 32'd0);

    exp_bytes[0] = 8'hA5;
    run_stream(1, 1, "single_a5");

    exp_bytes[0] = 8'h00;
    exp_bytes[1] = 8'hFF;
    exp_bytes[2] = 8'h3C;
    run_stream(3, 3, "b2b_00_ff_3c");

    for (int k = 0; k < 18; k++) exp_bytes[5'(k)] = 8'(k * 37 + 11);
    run_stream(18, 17, "fifo_full_18");

    // Reset while bit 3 of a zero byte is on the line, five bytes still queued.
    exp_bytes[0] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tx_dv = 1'b1;
      tx_byte = (k == 0) ? 8'h00 : 8'(8'h40 + k);
      @(negedge clk);
    end
    tx_dv = 1'b0;
    repeat (14) @(negedge clk);
    check("pre-reset serial", 32'(tx_serial), 32'd0);
    check("pre-reset busy", 32'(tx_busy), 32'd1);
    check("pre-reset empty", 32'(fifo_empty), 32'd0);
    rst = 1'b1;
    #1;
    check("async reset serial", 32'(tx_serial), 32'd1);
    check("async reset empty", 32'(fifo_empty), 32'd1);
    check("async reset busy", 32'(tx_busy), 32'd0);
    check("async reset done", 32'(tx_done), 32'd0);
    check("async reset ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      check($sformatf("post-reset serial t=%0d", t), 32'(tx_serial), 32'd1);
      check($sformatf("post-reset done t=%0d", t), 32'(tx_done), 32'd0);
      check($sformatf("post-reset busy t=%0d", t), 32'(tx_busy), 32'd0);
    end
    $display("[TB] mid-frame reset: line held idle after release");

`ifdef UART_TX_PARITY_EN
    exp_bytes[0] = 8'h07;
    run_stream(1, 1, "parity_07");
    exp_bytes[0] = 8'h07;
    exp_bytes[1] = 8'h01;
    run_stream(2, 2, "parity_07_01");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
